// File: rtl/psum_collector.sv
// Partial-sum collector: adds the k-th element of N PE rows and writes the sum
// to the global buffer, optionally accumulating onto the stored word.
module psum_collector #(
  parameter int N                        = 3,
  parameter int DATA_WIDTH               = 16,
  parameter int GLOBAL_BUFFER_ADDR_WIDTH = 10,
  parameter int OUT_LEN_WIDTH            = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                Start,
  input  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] base_addr,
  input  logic [OUT_LEN_WIDTH-1:0]            out_len,
  input  logic                                acc,
  input  logic [N*DATA_WIDTH-1:0]             psum_in,
  input  logic [N-1:0]                        psum_valid,
  output logic                                psum_ready,
  output logic                                gb_rd_en,
  output logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] gb_rd_addr,
  input  logic [DATA_WIDTH-1:0]               gb_rd_data,
  output logic                                gb_wr_en,
  output logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] gb_wr_addr,
  output logic [DATA_WIDTH-1:0]               gb_wr_data,
  output logic                                Done
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

  state_t                              state, next_state;
  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] base_q;
  logic [OUT_LEN_WIDTH-1:0]            len_q;
  logic                                acc_q;
  logic [OUT_LEN_WIDTH-1:0]            k_q;
  logic                                wr_pending;
  logic [DATA_WIDTH-1:0]               sum_q;
  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] addr_q;

  logic                                xfer;
  logic [DATA_WIDTH-1:0]               sum_c;
  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] addr_c;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // A transfer needs every PE valid at once; partial valid simply stalls.
  always_comb begin
    next_state = state;
    xfer       = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) next_state = (out_len == '0) ? S_DONE : S_COLLECT;
      end
      S_COLLECT: begin
        if (&psum_valid) begin
          xfer = 1'b1;
          if (k_q == len_q - OUT_LEN_WIDTH'(1)) next_state = S_FLUSH;
        end
      end
      S_FLUSH: next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) sum_c = sum_c + psum_in[i*DATA_WIDTH +: DATA_WIDTH];
    addr_c = base_q + GLOBAL_BUFFER_ADDR_WIDTH'(k_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      len_q      <= '0;
      acc_q      <= 1'b0;
      k_q        <= '0;
      wr_pending <= 1'b0;
      sum_q      <= '0;
      addr_q     <= '0;
    end else begin
      if (state == S_IDLE && Start) begin
        base_q <= base_addr;
        len_q  <= out_len;
        acc_q  <= acc;
        k_q    <= '0;
      end else if (xfer) begin
        k_q <= k_q + OUT_LEN_WIDTH'(1);
      end
      wr_pending <= xfer;
      if (xfer) begin
        sum_q  <= sum_c;
        addr_q <= addr_c;
      end
    end
  end

  // The read is issued in the transfer cycle so its data meets the registered sum one cycle later.
  assign psum_ready = (state == S_COLLECT);
  assign Done       = (state == S_DONE);
  assign gb_rd_en   = xfer & acc_q;
  assign gb_rd_addr = gb_rd_en ? addr_c : '0;
  assign gb_wr_en   = wr_pending;
  assign gb_wr_addr = wr_pending ? addr_q : '0;
  assign gb_wr_data = wr_pending ? (sum_q + (acc_q ? gb_rd_data : '0)) : '0;

endmodule
